// File: rtl/alu32_arb_pkg.sv
// alu32_arb_pkg: shared op codes, arbiter state encoding and counter width.
package alu32_arb_pkg;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_XOR = 3'b011;
    localparam logic [2:0] ALU_NOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLL = 3'b111;
    typedef enum logic {ST_IDLE = 1'b0, ST_HOLD = 1'b1} arb_st_e;
    localparam int ARB_CNT_W = 16;
endpackage

// File: rtl/alu32.sv
// alu32: combinational 32-bit ALU; SLT is a signed compare, SLL shifts by B[4:0].
module alu32
    import alu32_arb_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic [2:0]   S,
    output logic [W-1:0] R
);
    always_comb begin
        R = '0;
        case (S)
            ALU_AND: R = A & B;
            ALU_OR:  R = A | B;
            ALU_ADD: R = A + B;
            ALU_XOR: R = A ^ B;
            ALU_NOR: R = ~(A | B);
            ALU_SLT: R = {{(W-1){1'b0}}, $signed(A) < $signed(B)};
            ALU_SUB: R = A - B;
            default: R = A << B[4:0];
        endcase
    end
endmodule

// File: rtl/alu32_arbiter.sv
// alu32_arbiter: round-robin sharing of one alu32 between two valid/ready requesters.
// Optional ALU32_ARB_PERF_EN adds grant and conflict counters.
module alu32_arbiter
    import alu32_arb_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [2:0]   req0_op,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [2:0]   req1_op,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    output logic         resp0_valid,
    input  logic         resp0_ready,
    output logic         resp1_valid,
    input  logic         resp1_ready,
    output logic [W-1:0] resp_result,
    output logic         resp_zero
`ifdef ALU32_ARB_PERF_EN
    ,
    output logic [ARB_CNT_W-1:0] grant_cnt0,
    output logic [ARB_CNT_W-1:0] grant_cnt1,
    output logic [ARB_CNT_W-1:0] conflict_cnt
`endif
);
    arb_st_e      st_q, st_d;
    logic         owner_q, owner_d, last_q, last_d, zero_q, zero_d;
    logic [W-1:0] result_q, result_d, alu_r;
    logic         slot_free, grant, both, accept;
    alu32 #(.W(W)) u_alu (
        .A(grant ? req1_a : req0_a),
        .B(grant ? req1_b : req0_b),
        .S(grant ? req1_op : req0_op),
        .R(alu_r)
    );
    // Slot frees in the same cycle the owner consumes, enabling 1/cycle throughput.
    always_comb begin
        slot_free = (st_q == ST_IDLE) | (owner_q ? resp1_ready : resp0_ready);
        both      = req0_valid & req1_valid;
        grant     = both ? ~last_q : req1_valid;
        accept    = ~rst & slot_free & (req0_valid | req1_valid);
        st_d      = accept ? ST_HOLD : (slot_free ? ST_IDLE : st_q);
        owner_d   = accept ? grant : owner_q;
        last_d    = accept ? grant : last_q;
        result_d  = accept ? alu_r : result_q;
        zero_d    = accept ? (alu_r == '0) : zero_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            st_q     <= ST_IDLE;
            owner_q  <= 1'b0;
            last_q   <= 1'b1;
            result_q <= '0;
            zero_q   <= 1'b1;
        end else begin
            st_q     <= st_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end
    assign req0_ready  = accept & ~grant;
    assign req1_ready  = accept & grant;
    assign resp0_valid = (st_q == ST_HOLD) & ~owner_q;
    assign resp1_valid = (st_q == ST_HOLD) & owner_q;
    assign resp_result = result_q;
    assign resp_zero   = zero_q;
`ifdef ALU32_ARB_PERF_EN
    logic [ARB_CNT_W-1:0] gc0_q, gc1_q, cc_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            gc0_q <= '0;
            gc1_q <= '0;
            cc_q  <= '0;
        end else begin
            gc0_q <= gc0_q + ARB_CNT_W'(accept & ~grant);
            gc1_q <= gc1_q + ARB_CNT_W'(accept & grant);
            cc_q  <= cc_q + ARB_CNT_W'(accept & both);
        end
    end
    assign grant_cnt0   = gc0_q;
    assign grant_cnt1   = gc1_q;
    assign conflict_cnt = cc_q;
`endif
endmodule

// File: tb/tb_alu32_arbiter.sv
// tb_alu32_arbiter: directed vectors with hand-computed results for alu32_arbiter.
module tb_alu32_arbiter;
    import alu32_arb_pkg::*;
    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [2:0]  req0_op, req1_op;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        resp0_valid, resp0_ready, resp1_valid, resp1_ready;
    logic [31:0] resp_result;
    logic        resp_zero;
    int          n_chk = 0;
    int          n_err = 0;
`ifdef ALU32_ARB_PERF_EN
    logic [15:0] grant_cnt0, grant_cnt1, conflict_cnt;
`endif
    alu32_arbiter #(.W(32)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
        .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
        .resp_result(resp_result), .resp_zero(resp_zero)
`ifdef ALU32_ARB_PERF_EN
        , .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1), .conflict_cnt(conflict_cnt)
`endif
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    typedef struct { logic [2:0] op; logic [31:0] a, b, r; } vec_t;
    vec_t vecs[5] = '{
        '{ALU_SLT, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001},
        '{ALU_SLT, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000},
        '{ALU_NOR, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF},
        '{ALU_SUB, 32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE},
        '{ALU_XOR, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555}
    };
    initial begin
        rst = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_op = ALU_ADD; req1_op = ALU_ADD;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        resp0_ready = 1'b0; resp1_ready = 1'b0;
        tick();
        #1;
        chk("rst_req0_ready", {31'b0, req0_ready}, 32'd0);
        chk("rst_req1_ready", {31'b0, req1_ready}, 32'd0);
        tick();
        chk("rst_resp0_valid", {31'b0, resp0_valid}, 32'd0);
        chk("rst_resp1_valid", {31'b0, resp1_valid}, 32'd0);
        chk("rst_result", resp_result, 32'd0);
        chk("rst_zero", {31'b0, resp_zero}, 32'd1);
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst = 1'b0;
        tick();
        // single request
        req0_valid = 1'b1; req0_op = ALU_ADD; req0_a = 32'd5; req0_b = 32'd3;
        #1;
        chk("single_req0_ready", {31'b0, req0_ready}, 32'd1);
        chk("single_req1_ready", {31'b0, req1_ready}, 32'd0);
        tick();
        req0_valid = 1'b0;
        #1;
        chk("single_resp0_valid", {31'b0, resp0_valid}, 32'd1);
        chk("single_resp1_valid", {31'b0, resp1_valid}, 32'd0);
        chk("single_result", resp_result, 32'd8);
        chk("single_zero", {31'b0, resp_zero}, 32'd0);
        resp0_ready = 1'b1;
        tick();
        chk("single_drained", {31'b0, resp0_valid}, 32'd0);
        // tie from reset: grants alternate 0,1,0,1
        rst = 1'b1;
        tick();
        rst = 1'b0;
        resp0_ready = 1'b1; resp1_ready = 1'b1;
        req0_valid = 1'b1; req0_op = ALU_OR;  req0_a = 32'hF0F0_0000; req0_b = 32'h0000_0F0F;
        req1_valid = 1'b1; req1_op = ALU_SUB; req1_a = 32'h10;        req1_b = 32'h10;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("tie%0d_req0_ready", i), {31'b0, req0_ready}, {31'b0, i[0] == 1'b0});
            chk($sformatf("tie%0d_req1_ready", i), {31'b0, req1_ready}, {31'b0, i[0] == 1'b1});
            tick();
            chk($sformatf("tie%0d_resp0_valid", i), {31'b0, resp0_valid}, {31'b0, i[0] == 1'b0});
            chk($sformatf("tie%0d_resp1_valid", i), {31'b0, resp1_valid}, {31'b0, i[0] == 1'b1});
            chk($sformatf("tie%0d_result", i), resp_result, i[0] ? 32'h0 : 32'hF0F0_0F0F);
            chk($sformatf("tie%0d_zero", i), {31'b0, resp_zero}, {31'b0, i[0] == 1'b1});
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
        chk("tie_drained", {30'b0, resp0_valid, resp1_valid}, 32'd0);
        // backpressure
        resp0_ready = 1'b0; resp1_ready = 1'b0;
        req0_valid = 1'b1; req0_op = ALU_AND; req0_a = 32'hFFFF_0000; req0_b = 32'h0F0F_0F0F;
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_op = ALU_SLL; req1_a = 32'h1; req1_b = 32'h4;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("bp%0d_resp0_valid", i), {31'b0, resp0_valid}, 32'd1);
            chk($sformatf("bp%0d_result", i), resp_result, 32'h0F0F_0000);
            chk($sformatf("bp%0d_readys", i), {30'b0, req0_ready, req1_ready}, 32'd0);
            tick();
        end
        resp0_ready = 1'b1;
        #1;
        chk("bp_release_req1_ready", {31'b0, req1_ready}, 32'd1);
        tick();
        req1_valid = 1'b0;
        chk("bp_resp1_valid", {31'b0, resp1_valid}, 32'd1);
        chk("bp_resp0_valid", {31'b0, resp0_valid}, 32'd0);
        chk("bp_sll_result", resp_result, 32'h10);
        // back-to-back on req0 while req1's result is consumed
        resp1_ready = 1'b1;
        req0_valid = 1'b1; req0_op = ALU_ADD; req0_b = 32'd10;
        for (int i = 0; i < 4; i++) begin
            req0_a = 32'(i + 1);
            #1;
            chk($sformatf("b2b%0d_req0_ready", i), {31'b0, req0_ready}, 32'd1);
            tick();
            chk($sformatf("b2b%0d_resp0_valid", i), {31'b0, resp0_valid}, 32'd1);
            chk($sformatf("b2b%0d_result", i), resp_result, 32'(i + 11));
        end
        req0_valid = 1'b0;
        tick();
        chk("b2b_idle", {31'b0, resp0_valid}, 32'd0);
        // ALU op coverage through req1
        foreach (vecs[k]) begin
            req1_valid = 1'b1; req1_op = vecs[k].op; req1_a = vecs[k].a; req1_b = vecs[k].b;
            tick();
            req1_valid = 1'b0;
            chk($sformatf("op%0d_result", k), resp_result, vecs[k].r);
            chk($sformatf("op%0d_zero", k), {31'b0, resp_zero}, {31'b0, vecs[k].r == 32'd0});
            tick();
        end
        // reset mid-HOLD
        resp1_ready = 1'b0;
        req1_valid = 1'b1; req1_op = ALU_ADD; req1_a = 32'd7; req1_b = 32'd7;
        tick();
        chk("rh_resp1_valid", {31'b0, resp1_valid}, 32'd1);
        chk("rh_result", resp_result, 32'd14);
        rst = 1'b1; req0_valid = 1'b1; req0_op = ALU_ADD; req0_a = 32'd1; req0_b = 32'd1;
        #1;
        chk("rh_rst_readys", {30'b0, req0_ready, req1_ready}, 32'd0);
        tick();
        rst = 1'b0;
        chk("rh_resp_valids", {30'b0, resp0_valid, resp1_valid}, 32'd0);
        chk("rh_result_cleared", resp_result, 32'd0);
        chk("rh_zero", {31'b0, resp_zero}, 32'd1);
        #1;
        chk("rh_tie_req0_ready", {31'b0, req0_ready}, 32'd1);
        chk("rh_tie_req1_ready", {31'b0, req1_ready}, 32'd0);
        tick();
        chk("rh_tie_resp0_valid", {31'b0, resp0_valid}, 32'd1);
        chk("rh_tie_result", resp_result, 32'd2);
`ifdef ALU32_ARB_PERF_EN
        rst = 1'b1;
        tick();
        rst = 1'b0;
        resp0_ready = 1'b1; resp1_ready = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        repeat (3) tick();
        req1_valid = 1'b0;
        repeat (69998) tick();
        req0_valid = 1'b0;
        chk("perf_grant_cnt0", {16'b0, grant_cnt0}, 32'd4464);
        chk("perf_grant_cnt1", {16'b0, grant_cnt1}, 32'd1);
        chk("perf_conflict_cnt", {16'b0, conflict_cnt}, 32'd3);
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/alu32_arbiter.md
# alu32_arbiter

Shares one `alu32` instance between two requesters, for example the integer pipeline and a multi-cycle helper unit. Each requester uses a valid/ready request channel and a valid/ready response channel. Arbitration is round-robin. Each result is registered and held until the owning requester accepts it. The block adds a zero flag for branch use.

## Interface
Parameters:
- `W`, default 32: operand and result width; only 32 is supported.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req0_valid` / `req1_valid`  in  1  request present.
- `req0_ready` / `req1_ready`  out  1  request accepted on the edge where valid and ready are both high.
- `req0_op` / `req1_op`  in  3  ALU select, driven to `alu32.S`.
- `req0_a`, `req0_b` / `req1_a`, `req1_b`  in  32  operands.
- `resp0_valid` / `resp1_valid`  out  1  held result belongs to this requester.
- `resp0_ready` / `resp1_ready`  in  1  requester consumes the result.
- `resp_result`  out  32  held result, shared by both response channels.
- `resp_zero`  out  1  high when `resp_result == 0`.

## Operation
State machine `st`:
- IDLE: no result held.
- HOLD: result register valid; `owner` records which requester (0 or 1) it belongs to.

Request side:
- `slot_free` = (st==IDLE) | (st==HOLD & resp<owner>_ready).
- Grant when `slot_free`:
  - If only one `reqN_valid` is high, that requester wins.
  - If both are high, the requester other than `last` wins.
  - `last` is the requester granted most recently.
- `reqN_ready` = `slot_free` & (grant==N). This is a combinational path from `resp*_ready` to `req*_ready`; that path is required.
- On acceptance:
  - The muxed A/B/S values go through `alu32`.
  - R is captured into `result_q`, and `zero_q` = (R==0).
  - `owner` = N, `last` = N, st = HOLD.

Response side:
- `respN_valid` = (st==HOLD) & (owner==N).
- In HOLD, if the owner asserts ready and no new request is accepted, st goes to IDLE.
- In HOLD, if the owner asserts ready and a request is accepted in the same cycle, st stays HOLD with the new owner and data. This allows back-to-back transfers at 1 per cycle.
- `respN_ready` while `respN_valid` is low is ignored.
- While a result is held and not consumed, `req*_ready` stay low. The operand mux still follows the grant, but nothing is captured.

Reset values:
- st = IDLE, `owner` = 0, `last` = 1 (so requester 0 wins the first tie).
- `result_q` = 0, `zero_q` = 1.
- All ready and valid outputs are 0.

## Timing
- Latency: request accepted at edge N, so `respX_valid`, `resp_result` and `resp_zero` are valid from cycle N+1.
- Throughput: 1 operation per cycle when the owner keeps `resp_ready` high.
- With both requesters continuously valid, grants alternate 0,1,0,1 starting with 0 after reset.
- `rst` asserted mid-HOLD: the held result is dropped, and `respX_valid` is 0 from the next cycle. Any request present in the reset cycle is not accepted.
- Operand and op inputs only need to be stable in the cycle they are accepted.

## Configuration
- `ALU32_ARB_PERF_EN` defined:
  - Adds outputs `grant_cnt0` and `grant_cnt1` (16 bit each). Each increments once per accepted request for its requester.
  - Adds output `conflict_cnt` (16 bit). It increments in every cycle where both `req*_valid` are high and a grant is made.
  - All three counters wrap from 16'hFFFF to 0 and clear on `rst`.
- Not defined: these ports and counters are absent, and request/response behaviour is identical.

## Structure
- Shared package `alu32_arb_pkg`:
  - Op codes: ALU_AND=3'b000, ALU_OR=3'b001, ALU_ADD=3'b010, ALU_XOR=3'b011, ALU_NOR=3'b100, ALU_SLT=3'b101, ALU_SUB=3'b110, ALU_SLL=3'b111.
  - State encoding ST_IDLE=1'b0, ST_HOLD=1'b1.
  - Counter width constant ARB_CNT_W=16.
- One sub-module: the existing `alu32`, instantiated once with ports `A`, `B`, `S` and `R`.
- Arbitration logic stays inline.

## Test plan
- Single request: req0 with op=ALU_ADD, a=32'h0000_0005, b=32'h0000_0003 → at the next cycle `resp0_valid`=1, `resp_result`=32'h0000_0008, `resp_zero`=0, `resp1_valid`=0.
- Tie: both valid from reset, resp ready held high, req0 ALU_OR 32'hF0F0_0000 | 32'h0000_0F0F, req1 ALU_SUB 32'h10 - 32'h10 → grants go 0,1,0,1. The req1 response shows `resp_result`=0 and `resp_zero`=1.
- Backpressure: `resp0_ready`=0 for 3 cycles after a result → `resp0_valid` and `resp_result` stay stable and both `req*_ready` stay 0. When ready rises, a pending req1 is accepted in the same cycle.
- Back-to-back: req0 valid for 4 cycles with `resp0_ready`=1 → 4 results on 4 consecutive cycles and no IDLE bubble.
- Reset mid-HOLD: `rst` pulsed while `resp1_valid`=1 → next cycle all resp valid=0 and outputs at reset values. A subsequent tie grants requester 0.
- `ALU32_ARB_PERF_EN`: run 70000 grants to req0 → `grant_cnt0` = 70000 mod 65536 = 4464. `conflict_cnt` equals the number of tie cycles.
